// File: rtl/count_seq_ctrl_if.sv
// Host-side command and status bundle for count_seq_ctrl.
// The host (master) issues run commands and run controls; the controller
// (slave) returns the handshake ready, the live count and the event pulses.
interface count_seq_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_down;
  logic             cfg_reload;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc_pulse;
  logic             done;

  modport master (
    output start_valid, cfg_limit, cfg_down, cfg_reload, pause, abort,
    input  start_ready, count, busy, tc_pulse, done
  );

  modport slave (
    input  start_valid, cfg_limit, cfg_down, cfg_reload, pause, abort,
    output start_ready, count, busy, tc_pulse, done
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit counter.
// A run command (limit, direction, reload mode) is accepted in IDLE over a
// valid/ready handshake. In RUN the counter steps from its start value to its
// terminal value, either once (then DONE for one cycle) or repeatedly.
// Every output is registered; busy and start_ready decode from the state.
// WIDTH must match the WIDTH of the connected interface instance.
module count_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  count_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             down_q, down_d;
  logic             reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;

  // Start and terminal values of the latched run: up runs 0..lim, down runs lim..0.
  always_comb begin
    start_val = down_q ? lim_q : '0;
    term_val  = down_q ? '0    : lim_q;
  end

  // Next-state, next-count and event decode; priority abort > pause > terminal/step.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    lim_d    = lim_q;
    down_d   = down_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          lim_d    = bus.cfg_limit;
          down_d   = bus.cfg_down;
          reload_d = bus.cfg_reload;
          count_d  = bus.cfg_down ? bus.cfg_limit : '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (bus.pause) begin
          // Hold everything; no events while paused.
          state_d = S_RUN;
        end else if (count_q == term_val) begin
          tc_d = 1'b1;
          if (reload_q) begin
            count_d = start_val;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (down_q) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end

      S_DONE: begin
        // One cycle only; an abort here still clears the count.
        state_d = S_IDLE;
        if (bus.abort) begin
          count_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, counter, latched config and event registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      lim_q    <= '0;
      down_q   <= 1'b0;
      reload_q <= 1'b0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      lim_q    <= lim_d;
      down_q   <= down_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.tc_pulse    = tc_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.start_ready = (state_q == S_IDLE);

endmodule
